// File: rtl/axi_helper.sv
// ============================================================================
// Module   : axi_helper (package)
// Purpose  : Shared response codes and scheduler state encoding.
// Revision : 1.0
// ============================================================================
`default_nettype none

package axi_helper;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_t;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ISSUE    = 3'd1,
      ST_WAIT_ACC = 3'd2,
      ST_WAIT_B   = 3'd3,
      ST_RESP     = 3'd4
   } wr_sched_state_t;

endpackage

`default_nettype wire

// File: rtl/axi_wr_sched_rr_arb.sv
// ============================================================================
// Module   : rr_arb
// Purpose  : Round-robin pick starting at a registered pointer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arb #(
   parameter  int NREQ = 2,
   localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] i_req,
   input  logic            i_adv,
   input  logic [IDXW-1:0] i_adv_idx,
   output logic [NREQ-1:0] o_gnt,
   output logic [IDXW-1:0] o_idx,
   output logic            o_any
);

   logic [IDXW-1:0] r_ptr;

   // First requester at or after the pointer, wrapping modulo NREQ.
   always_comb begin
      o_any = 1'b0;
      o_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!o_any && i_req[(int'(r_ptr) + k) % NREQ]) begin
            o_any = 1'b1;
            o_idx = IDXW'((int'(r_ptr) + k) % NREQ);
         end
      end
   end

   always_comb begin
      o_gnt = '0;
      for (int i = 0; i < NREQ; i++) begin
         o_gnt[i] = o_any && (o_idx == IDXW'(i));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (i_adv) begin
         r_ptr <= (i_adv_idx == IDXW'(NREQ - 1)) ? '0 : i_adv_idx + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/axi_wr_sched.sv
// ============================================================================
// Module   : axi_wr_sched
// Purpose  : Single-outstanding AXI write scheduler with B-channel watchdog.
// Revision : 1.0
// ============================================================================
`default_nettype none

module axi_wr_sched
   import axi_helper::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int NREQ        = 2,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic                   ACLK,
   input  logic                   ARESETn,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ*ADDR_W-1:0] req_addr,
   input  logic [NREQ*DATA_W-1:0] req_data,
   output logic [NREQ-1:0]        req_ready,
   output logic [NREQ-1:0]        rsp_valid,
   output logic [1:0]             rsp_code,
   output logic [ADDR_W-1:0]      aw_tx_data,
   output logic                   aw_tx_en,
   input  logic                   aw_tx_hold,
   output logic [DATA_W-1:0]      w_tx_data,
   output logic                   w_tx_en,
   input  logic                   w_tx_hold,
   input  logic [1:0]             b_rx_data,
   input  logic                   b_new_data,
   output logic                   busy,
   output logic                   timeout_err
);

   localparam int IDXW  = $clog2(NREQ);
   localparam int CNT_W = $clog2(TIMEOUT_CYC);

   wr_sched_state_t r_state, w_next;
   logic [IDXW-1:0]   r_gnt_idx;
   logic [ADDR_W-1:0] r_aw_data;
   logic [DATA_W-1:0] r_w_data;
   logic [1:0]        r_b_code;
   logic              r_b_pending;
   logic [CNT_W-1:0]  r_cnt;

   logic [NREQ-1:0] w_gnt;
   logic [IDXW-1:0] w_idx;
   logic            w_any;
   logic            w_expire;

   rr_arb #(.NREQ(NREQ)) u_arb (
      .clk       (ACLK),
      .rst_n     (ARESETn),
      .i_req     (req_valid),
      .i_adv     (r_state == ST_RESP),
      .i_adv_idx (r_gnt_idx),
      .o_gnt     (w_gnt),
      .o_idx     (w_idx),
      .o_any     (w_any)
   );

   assign w_expire = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:     if (w_any) w_next = ST_ISSUE;
         ST_ISSUE:    w_next = ST_WAIT_ACC;
         ST_WAIT_ACC: if (!aw_tx_hold && !w_tx_hold) w_next = ST_WAIT_B;
         ST_WAIT_B:   if (r_b_pending || b_new_data || w_expire) w_next = ST_RESP;
         ST_RESP:     w_next = ST_IDLE;
         default:     w_next = ST_IDLE;
      endcase
   end

   // Early B beats are held in r_b_pending so WAIT_B can pass straight through.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_gnt_idx   <= '0;
         r_aw_data   <= '0;
         r_w_data    <= '0;
         r_b_code    <= '0;
         r_b_pending <= 1'b0;
         r_cnt       <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_gnt_idx <= w_idx;
                  r_aw_data <= req_addr[int'(w_idx)*ADDR_W +: ADDR_W];
                  r_w_data  <= req_data[int'(w_idx)*DATA_W +: DATA_W];
               end
            end
            ST_ISSUE, ST_WAIT_ACC: begin
               if (b_new_data) begin
                  r_b_code    <= b_rx_data;
                  r_b_pending <= 1'b1;
               end
            end
            ST_WAIT_B: begin
               if (!r_b_pending) begin
                  if (b_new_data) begin
                     r_b_code    <= b_rx_data;
                     r_b_pending <= 1'b1;
                  end else if (w_expire) begin
                     r_b_code <= SLVERR;
                  end
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_RESP: begin
               r_b_pending <= 1'b0;
               r_cnt       <= '0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      req_ready   = '0;
      rsp_valid   = '0;
      rsp_code    = OKAY;
      aw_tx_en    = 1'b0;
      w_tx_en     = 1'b0;
      busy        = (r_state != ST_IDLE);
      timeout_err = 1'b0;
      case (r_state)
         ST_IDLE:  if (ARESETn) req_ready = w_gnt;
         ST_ISSUE: begin
            aw_tx_en = 1'b1;
            w_tx_en  = 1'b1;
         end
         ST_WAIT_B: timeout_err = !r_b_pending && !b_new_data && w_expire;
         ST_RESP: begin
            for (int i = 0; i < NREQ; i++) begin
               rsp_valid[i] = (r_gnt_idx == IDXW'(i));
            end
            rsp_code = r_b_code;
         end
         default: ;
      endcase
   end

   assign aw_tx_data = r_aw_data;
   assign w_tx_data  = r_w_data;

endmodule

`default_nettype wire

// File: tb/tb_axi_wr_sched.sv
// ============================================================================
// Module   : tb_axi_wr_sched
// Purpose  : Directed self-checking bench for axi_wr_sched (TIMEOUT_CYC=8).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_axi_wr_sched;

   localparam int NREQ = 2;
   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int TO   = 8;

   logic              ACLK;
   logic              ARESETn;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ-1:0]   rsp_valid;
   logic [1:0]        rsp_code;
   logic [AW-1:0]     aw_tx_data;
   logic              aw_tx_en;
   logic              aw_tx_hold;
   logic [DW-1:0]     w_tx_data;
   logic              w_tx_en;
   logic              w_tx_hold;
   logic [1:0]        b_rx_data;
   logic              b_new_data;
   logic              busy;
   logic              timeout_err;

   axi_wr_sched #(.ADDR_W(AW), .DATA_W(DW), .NREQ(NREQ), .TIMEOUT_CYC(TO)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_code(rsp_code),
      .aw_tx_data(aw_tx_data), .aw_tx_en(aw_tx_en), .aw_tx_hold(aw_tx_hold),
      .w_tx_data(w_tx_data), .w_tx_en(w_tx_en), .w_tx_hold(w_tx_hold),
      .b_rx_data(b_rx_data), .b_new_data(b_new_data),
      .busy(busy), .timeout_err(timeout_err)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge ACLK);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic set_slot(input int g, input logic [31:0] a, input logic [31:0] d);
      req_addr[g*AW +: AW] = a;
      req_data[g*DW +: DW] = d;
   endtask

   task automatic chk_quiet(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_rdy"}, req_ready, 0);
      check({tag, "_rsp"}, rsp_valid, 0);
      check({tag, "_code"}, rsp_code, 0);
      check({tag, "_en"}, {aw_tx_en, w_tx_en}, 0);
      check({tag, "_to"}, timeout_err, 0);
      check({tag, "_awd"}, aw_tx_data, 0);
      check({tag, "_wd"}, w_tx_data, 0);
   endtask

   // Zero-wait transaction starting in the grant cycle; B arrives in WAIT_B.
   task automatic txn(input int g, input logic [31:0] ea, input logic [31:0] ed,
                      input logic [1:0] code, input bit drop);
      settle();
      check("grant", req_ready, 64'(1 << g));
      check("en_idle", {aw_tx_en, w_tx_en}, 0);
      nxt();
      if (drop) req_valid = '0;
      settle();
      check("issue_en", {aw_tx_en, w_tx_en}, 2'b11);
      check("aw_data", aw_tx_data, ea);
      check("w_data", w_tx_data, ed);
      check("rdy_issue", req_ready, 0);
      nxt();
      settle();
      check("acc_en", {aw_tx_en, w_tx_en}, 0);
      nxt();
      b_new_data = 1'b1;
      b_rx_data  = code;
      settle();
      check("rsp_waitb", rsp_valid, 0);
      nxt();
      b_new_data = 1'b0;
      settle();
      check("rsp_v", rsp_valid, 64'(1 << g));
      check("rsp_code", rsp_code, code);
      check("rdy_resp", req_ready, 0);
      check("to_resp", timeout_err, 0);
      nxt();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ARESETn    = 1'b0;
      req_valid  = '0;
      req_addr   = '0;
      req_data   = '0;
      aw_tx_hold = 1'b0;
      w_tx_hold  = 1'b0;
      b_rx_data  = 2'b00;
      b_new_data = 1'b0;
      nxt();
      nxt();
      settle();
      chk_quiet("reset");
      nxt();
      ARESETn = 1'b1;

      // Single request, ideal channels.
      set_slot(0, 32'h0000_0100, 32'hDEAD_BEEF);
      req_valid = 2'b01;
      txn(0, 32'h0000_0100, 32'hDEAD_BEEF, 2'b00, 1'b1);
      settle();
      check("idle_after", busy, 0);

      // Restart pointer at 0, then contention with both requesters held.
      nxt();
      ARESETn = 1'b0;
      nxt();
      ARESETn = 1'b1;
      set_slot(1, 32'h0000_0200, 32'hCAFE_F00D);
      req_valid = 2'b11;
      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 0) txn(0, 32'h0000_0100, 32'hDEAD_BEEF, 2'(i), 1'b0);
         else            txn(1, 32'h0000_0200, 32'hCAFE_F00D, 2'(i), 1'b0);
      end
      req_valid = '0;

      // Skewed accept then watchdog expiry; a stray B in the grant cycle is ignored.
      set_slot(0, 32'h0000_0300, 32'h1111_2222);
      req_valid  = 2'b01;
      b_new_data = 1'b1;
      b_rx_data  = 2'b00;
      settle();
      check("sk_grant", req_ready, 2'b01);
      nxt();
      req_valid  = '0;
      b_new_data = 1'b0;
      settle();
      check("sk_issue", {aw_tx_en, w_tx_en}, 2'b11);
      for (int c = 2; c <= 16; c++) begin
         nxt();
         aw_tx_hold = (c <= 4);
         w_tx_hold  = (c <= 7);
         settle();
         check("sk_no_reen", {aw_tx_en, w_tx_en}, 0);
         check("sk_rsp", rsp_valid, 0);
         check("sk_to", timeout_err, (c == 16) ? 1 : 0);
      end
      nxt();
      aw_tx_hold = 1'b0;
      w_tx_hold  = 1'b0;
      settle();
      check("to_rsp", rsp_valid, 2'b01);
      check("to_code", rsp_code, 2'b10);
      check("to_pulse_end", timeout_err, 0);
      nxt();
      settle();
      check("to_idle", busy, 0);

      // B arrives in the expiry cycle: real response wins.
      set_slot(1, 32'h0000_0400, 32'h5555_AAAA);
      req_valid = 2'b10;
      settle();
      check("ex_grant", req_ready, 2'b10);
      nxt();
      req_valid = '0;
      for (int c = 2; c <= 10; c++) begin
         nxt();
         b_new_data = (c == 10);
         b_rx_data  = 2'b00;
         settle();
         check("ex_to", timeout_err, 0);
         check("ex_rsp", rsp_valid, 0);
      end
      nxt();
      b_new_data = 1'b0;
      settle();
      check("ex_rsp_v", rsp_valid, 2'b10);
      check("ex_code", rsp_code, 2'b00);
      check("ex_to_end", timeout_err, 0);
      nxt();

      // Early SLVERR during WAIT_ACC.
      set_slot(0, 32'h0000_0500, 32'h0BAD_F00D);
      req_valid = 2'b01;
      settle();
      check("eb_grant", req_ready, 2'b01);
      nxt();
      req_valid = '0;
      nxt();
      w_tx_hold  = 1'b1;
      b_new_data = 1'b1;
      b_rx_data  = 2'b10;
      settle();
      check("eb_rsp2", rsp_valid, 0);
      nxt();
      b_new_data = 1'b0;
      nxt();
      w_tx_hold = 1'b0;
      settle();
      check("eb_rsp4", rsp_valid, 0);
      nxt();
      settle();
      check("eb_waitb", rsp_valid, 0);
      check("eb_busy", busy, 1);
      nxt();
      settle();
      check("eb_rsp_v", rsp_valid, 2'b01);
      check("eb_code", rsp_code, 2'b10);
      check("eb_to", timeout_err, 0);
      nxt();

      // Reset during WAIT_B; afterwards req1 alone is granted at once.
      set_slot(0, 32'h0000_0600, 32'h6666_0000);
      req_valid = 2'b01;
      settle();
      check("rm_grant", req_ready, 2'b01);
      nxt();
      req_valid = '0;
      nxt();
      nxt();
      settle();
      check("rm_in_waitb", busy, 1);
      nxt();
      ARESETn   = 1'b0;
      req_valid = 2'b10;
      set_slot(1, 32'h0000_0700, 32'h7777_0000);
      settle();
      chk_quiet("rm");
      nxt();
      settle();
      check("rm_hold_rsp", rsp_valid, 0);
      ARESETn = 1'b1;
      settle();
      check("rm_rel_busy", busy, 0);
      txn(1, 32'h0000_0700, 32'h7777_0000, 2'b01, 1'b1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/axi_wr_sched.md
Name: axi_wr_sched

Overview:
- Write-transaction scheduler in front of the manager's AW, W and B channels.
- Arbitrates single-beat write requests from NREQ requesters using round-robin.
- For the granted request it pulses the AW and W channel enables together, waits for both beats to be accepted, then waits for the B response and routes it back to the owning requester.
- Exactly one write is outstanding at a time. A watchdog converts a missing B response into SLVERR.

Parameters:
- ADDR_W, 32, address width of AW tx data
- DATA_W, 32, data width of W tx data
- NREQ, 2, number of requesters (2..8)
- TIMEOUT_CYC, 256, cycles spent in WAIT_B before a forced SLVERR (>=2)

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  request pending per requester
- req_addr  in  NREQ*ADDR_W  packed addresses; requester i uses slice i
- req_data  in  NREQ*DATA_W  packed write data
- req_ready  out  NREQ  one-cycle grant/accept pulse
- rsp_valid  out  NREQ  one-cycle response pulse to the owner
- rsp_code  out  2  resp_t; valid only while any rsp_valid bit is high
- aw_tx_data  out  ADDR_W  address to the AW TX channel
- aw_tx_en  out  1  one-cycle load pulse to the AW channel
- aw_tx_hold  in  1  AW channel holds an unaccepted beat
- w_tx_data  out  DATA_W  data to the W TX channel
- w_tx_en  out  1  one-cycle load pulse to the W channel
- w_tx_hold  in  1  W channel holds an unaccepted beat
- b_rx_data  in  2  BRESP from the B RX channel
- b_new_data  in  1  one-cycle pulse: new BRESP available
- busy  out  1  state != IDLE
- timeout_err  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset (asynchronous, ARESETn low): state=IDLE, rr pointer=0, all outputs 0, b_pending=0, counter=0. An in-flight transaction is dropped and no rsp_valid is issued for it.
- FSM states: IDLE, ISSUE, WAIT_ACC, WAIT_B, RESP.
- IDLE:
  - If any req_valid bit is high, grant the first requester at or after the rr pointer, wrapping modulo NREQ.
  - In that same cycle: pulse req_ready[g], register addr/data into aw_tx_data/w_tx_data, store g, go to ISSUE.
  - Requesters hold valid/addr/data until they see req_ready, then drop or change them. In this cycle req_ready must be the only pulse.
- ISSUE (exactly 1 cycle): aw_tx_en=1 and w_tx_en=1 together; go to WAIT_ACC.
- WAIT_ACC: minimum dwell 1 cycle. Leave to WAIT_B on the first cycle in which aw_tx_hold=0 and w_tx_hold=0; the two may clear in different cycles.
- b_pending:
  - A b_new_data pulse seen in ISSUE or WAIT_ACC latches b_rx_data and sets b_pending.
  - On entering WAIT_B with b_pending=1, go straight to RESP the next cycle.
- WAIT_B:
  - The counter increments every cycle from 0.
  - On b_new_data, latch b_rx_data and go to RESP.
  - When the counter reaches TIMEOUT_CYC-1 with no b_new_data: latch SLVERR, pulse timeout_err, go to RESP.
  - If b_new_data arrives in the expiry cycle, the real response wins and there is no timeout_err.
- RESP (1 cycle): rsp_valid[g]=1, rsp_code=latched value; rr pointer=(g+1) mod NREQ; clear b_pending and counter; go to IDLE.
- b_new_data in IDLE, RESP or WAIT_B after the latch is ignored (stray response).
- tx_data outputs hold their value until the next grant. tx_en is never asserted outside ISSUE.
- Minimum latency (zero-wait channels):
  - cycle 0: grant
  - cycle 1: ISSUE
  - cycle 2: WAIT_ACC
  - cycle 3: WAIT_B with b_new_data
  - cycle 4: rsp_valid
  - Back-to-back grants are therefore at least 5 cycles apart.

Decomposition:
- axi_helper package: resp_t (OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11) and wr_sched_state_t enum.
- Sub-module rr_arb #(NREQ): combinational round-robin pick plus registered pointer update. Inputs: req vector, advance pulse, granted index. Outputs: grant one-hot and index.

Test Plan:
- Single request: req0 with addr 0x100, data 0xDEAD_BEEF; ideal channels; b_new_data with OKAY at cycle 3 -> req_ready[0] at cycle 0, aw/w_tx_en at cycle 1, rsp_valid[0] with code 00 at cycle 4.
- Contention: req0 and req1 held high for 4 transactions -> grant order 0,1,0,1; each rsp_valid goes only to its owner.
- Skewed accept: aw_tx_hold high for 3 cycles, w_tx_hold for 6 -> WAIT_B entered the cycle after w_tx_hold drops; no tx_en re-pulse.
- Early B: b_new_data with SLVERR during WAIT_ACC -> latched; rsp_code 10 one cycle after entering WAIT_B.
- Timeout: TIMEOUT_CYC=8, no b_new_data -> timeout_err pulse after 8 WAIT_B cycles, rsp_code 10. Repeat with b_new_data (OKAY) in the expiry cycle -> code 00, no timeout_err.
- Reset mid-op: ARESETn low during WAIT_B -> all outputs 0 immediately, no rsp_valid; after release, req1 alone is granted at the first IDLE cycle.
